// File: rtl/tick_timer_if.sv
// tick_timer_if: groups the tick_timer control and status signals.
//   presc_in     : divided-clock level from the prescaler, synchronous to clk_in
//   enable       : level; 1 = arm/run, 0 = stop and clear
//   one_shot     : latched when the timer arms; 1 = stop after the first period
//   period       : terminal count (timer counts 0..period inclusive)
//   compare      : PWM threshold
//   count        : current tick count
//   pwm_out      : PWM waveform
//   period_pulse : one-cycle pulse at each wrap
//   running      : high while the timer is in RUN
// The master modport drives the configuration; the slave modport is the timer.
interface tick_timer_if #(
  parameter int WIDTH = 16
);
  logic             presc_in;
  logic             enable;
  logic             one_shot;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] compare;
  logic [WIDTH-1:0] count;
  logic             pwm_out;
  logic             period_pulse;
  logic             running;

  modport master (
    output presc_in, enable, one_shot, period, compare,
    input  count, pwm_out, period_pulse, running
  );

  modport slave (
    input  presc_in, enable, one_shot, period, compare,
    output count, pwm_out, period_pulse, running
  );
endinterface

// File: rtl/tick_timer.sv
// tick_timer: turns the prescaler's divided-clock level into single-cycle tick
// enables (all logic on clk_in) and runs a programmable period counter on them,
// producing a PWM waveform and a once-per-period pulse.
//   clk_in : system clock (same clock as the prescaler)
//   reset  : synchronous, active-high reset
//   bus    : tick_timer_if slave modport (config inputs, count/pwm/pulse/running)
// Parameters:
//   WIDTH           : width of count, period and compare
//   TICK_BOTH_EDGES : 0 = tick on rising edges of presc_in, 1 = on both edges
module tick_timer #(
  parameter int WIDTH           = 16,
  parameter bit TICK_BOTH_EDGES = 1'b0
) (
  input  logic          clk_in,
  input  logic          reset,
  tick_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic             presc_d;
  logic             tick;
  logic             one_shot_sh;
  logic             period_pulse_r;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] period_sh;
  logic [WIDTH-1:0] compare_sh;

  function automatic logic edge_tick(input logic cur, input logic prev);
    if (TICK_BOTH_EDGES) return cur ^ prev;
    else                 return cur & ~prev;
  endfunction

  // Tick is combinational so the count moves on the edge where the prescaler
  // edge is first seen in the clk_in domain.
  assign tick = edge_tick(bus.presc_in, presc_d);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      presc_d        <= 1'b0;
      state          <= IDLE;
      count_r        <= '0;
      period_pulse_r <= 1'b0;
      period_sh      <= '0;
      compare_sh     <= '0;
      one_shot_sh    <= 1'b0;
    end else begin
      presc_d        <= bus.presc_in;
      period_pulse_r <= 1'b0;
      case (state)
        IDLE: begin
          count_r <= '0;
          if (bus.enable) begin
            state       <= RUN;
            period_sh   <= bus.period;
            compare_sh  <= bus.compare;
            one_shot_sh <= bus.one_shot;
          end
        end
        RUN: begin
          // A stop request beats a coincident tick: no wrap, no pulse.
          if (!bus.enable) begin
            state   <= IDLE;
            count_r <= '0;
          end else if (tick) begin
            // Wrap check comes before the increment, so period = all-ones
            // never overflows the counter.
            if (count_r == period_sh) begin
              count_r        <= '0;
              period_pulse_r <= 1'b1;
              // Shadows only reload here so a period never changes mid-way.
              period_sh      <= bus.period;
              compare_sh     <= bus.compare;
              if (one_shot_sh) state <= DONE;
            end else begin
              count_r <= count_r + WIDTH'(1);
            end
          end
        end
        DONE: begin
          // Re-arming needs enable to drop first.
          count_r <= '0;
          if (!bus.enable) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          count_r <= '0;
        end
      endcase
    end
  end

  // Outputs decode registered state only; no path from the inputs.
  assign bus.count        = count_r;
  assign bus.running      = (state == RUN);
  assign bus.pwm_out      = (state == RUN) && (count_r < compare_sh);
  assign bus.period_pulse = period_pulse_r;

endmodule

// File: tb/tb_tick_timer.sv
// tb_tick_timer: directed bench for tick_timer. Two instances share a
// DIVISOR=4 style prescaler level (toggles every 4 clocks): dut_a ticks on
// rising edges only, dut_b on both edges.
module tb_tick_timer;

  logic clk = 1'b0;
  logic reset;
  logic presc;
  int   pdiv;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  tick_timer_if #(.WIDTH(16)) ifa ();
  tick_timer_if #(.WIDTH(16)) ifb ();

  tick_timer #(.WIDTH(16), .TICK_BOTH_EDGES(1'b0)) dut_a (
    .clk_in (clk),
    .reset  (reset),
    .bus    (ifa)
  );

  tick_timer #(.WIDTH(16), .TICK_BOTH_EDGES(1'b1)) dut_b (
    .clk_in (clk),
    .reset  (reset),
    .bus    (ifb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
    pdiv++;
    if (pdiv == 4) begin
      pdiv  = 0;
      presc = ~presc;
    end
    ifa.presc_in = presc;
    ifb.presc_in = presc;
  endtask

  task automatic cycn(input int n);
    repeat (n) cyc();
  endtask

  // Cycles until the next period_pulse; 0 if the budget runs out.
  task automatic wait_pulse(input bit sel, input int budget, output int n);
    int i;
    n = 0;
    i = 0;
    while (n == 0 && i < budget) begin
      cyc();
      i++;
      if ((sel ? ifb.period_pulse : ifa.period_pulse) === 1'b1) n = i;
    end
  endtask

  // Number of pwm_out-high samples over n cycles starting with the current one.
  task automatic pwm_hi(input bit sel, input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      if ((sel ? ifb.pwm_out : ifa.pwm_out) === 1'b1) hi++;
      cyc();
    end
  endtask

  initial begin
    int n;
    int hi;
    int pc;
    reset = 1'b1;
    presc = 1'b0;
    pdiv  = 0;
    ifa.presc_in = 1'b0; ifa.enable = 1'b0; ifa.one_shot = 1'b0;
    ifa.period   = '0;   ifa.compare = '0;
    ifb.presc_in = 1'b0; ifb.enable = 1'b0; ifb.one_shot = 1'b0;
    ifb.period   = '0;   ifb.compare = '0;
    cycn(3);
    chk("rst_count",   ifa.count, 0);
    chk("rst_pwm",     ifa.pwm_out, 0);
    chk("rst_pulse",   ifa.period_pulse, 0);
    chk("rst_running", ifa.running, 0);
    reset = 1'b0;

    // 1: period=3, compare=2, tick every 8 clocks
    ifa.period = 16'd3; ifa.compare = 16'd2; ifa.enable = 1'b1;
    wait_pulse(0, 100, n);
    chk("t1_first_pulse", (n != 0), 1);
    chk("t1_cnt0", ifa.count, 0);
    chk("t1_run",  ifa.running, 1);
    for (int k = 1; k <= 4; k++) begin
      cycn(8);
      chk("t1_cnt_step", ifa.count, k % 4);
      chk("t1_pulse_step", ifa.period_pulse, (k == 4) ? 1 : 0);
    end
    pwm_hi(0, 32, hi);
    chk("t1_pwm_hi", hi, 16);
    chk("t1_pulse_32", ifa.period_pulse, 1);

    // 2: one-shot
    ifa.enable = 1'b0;
    cyc();
    ifa.one_shot = 1'b1; ifa.enable = 1'b1;
    wait_pulse(0, 100, n);
    chk("t2_pulse", (n != 0), 1);
    chk("t2_done_run", ifa.running, 0);
    chk("t2_done_cnt", ifa.count, 0);
    chk("t2_done_pwm", ifa.pwm_out, 0);
    pc = 0;
    repeat (64) begin
      cyc();
      if (ifa.period_pulse === 1'b1) pc++;
    end
    chk("t2_no_restart", pc, 0);
    chk("t2_still_done", ifa.running, 0);
    ifa.enable = 1'b0;
    cyc();
    ifa.enable = 1'b1;
    cycn(2);
    chk("t2_rearm_run", ifa.running, 1);
    wait_pulse(0, 100, n);
    chk("t2_rearm_pulse", (n != 0), 1);
    chk("t2_rearm_done", ifa.running, 0);

    // 3: period change mid-period
    ifa.enable = 1'b0; ifa.one_shot = 1'b0; ifa.period = 16'd3;
    cyc();
    ifa.enable = 1'b1;
    wait_pulse(0, 100, n);
    cycn(8);
    chk("t3_cnt1", ifa.count, 1);
    ifa.period = 16'd1;
    cycn(8);
    chk("t3_cnt2", ifa.count, 2);
    cycn(8);
    chk("t3_cnt3", ifa.count, 3);
    cycn(8);
    chk("t3_wrap_cnt", ifa.count, 0);
    chk("t3_wrap_pulse", ifa.period_pulse, 1);
    wait_pulse(0, 100, n);
    chk("t3_interval1", n, 16);
    wait_pulse(0, 100, n);
    chk("t3_interval2", n, 16);

    // 4: period=0, compare 0 then 5
    ifa.enable = 1'b0; ifa.period = 16'd0; ifa.compare = 16'd0;
    cyc();
    ifa.enable = 1'b1;
    wait_pulse(0, 100, n);
    wait_pulse(0, 100, n);
    chk("t4_interval", n, 8);
    pwm_hi(0, 16, hi);
    chk("t4_pwm_c0", hi, 0);
    ifa.compare = 16'd5;
    wait_pulse(0, 100, n);
    chk("t4_interval_b", n, 8);
    pwm_hi(0, 16, hi);
    chk("t4_pwm_c5", hi, 16);

    // 5: both-edge ticks, period=7
    ifb.period = 16'd7; ifb.compare = 16'd4; ifb.enable = 1'b1;
    wait_pulse(1, 200, n);
    chk("t5_first_pulse", (n != 0), 1);
    wait_pulse(1, 100, n);
    chk("t5_interval", n, 32);
    cycn(4);
    chk("t5_cnt1", ifb.count, 1);
    cycn(4);
    chk("t5_cnt2", ifb.count, 2);
    pwm_hi(1, 32, hi);
    chk("t5_pwm_hi", hi, 16);

    // 6a: stop coinciding with the wrap tick
    ifa.enable = 1'b0; ifa.period = 16'd3; ifa.compare = 16'd2;
    cyc();
    ifa.enable = 1'b1;
    wait_pulse(0, 100, n);
    cycn(31);
    chk("t6a_cnt3", ifa.count, 3);
    ifa.enable = 1'b0;
    cyc();
    chk("t6a_pulse", ifa.period_pulse, 0);
    chk("t6a_run",   ifa.running, 0);
    chk("t6a_cnt",   ifa.count, 0);
    chk("t6a_pwm",   ifa.pwm_out, 0);
    pc = 0;
    repeat (8) begin
      cyc();
      if (ifa.period_pulse === 1'b1) pc++;
    end
    chk("t6a_no_pulse", pc, 0);

    // 6b: reset at the wrap tick
    ifa.enable = 1'b1;
    wait_pulse(0, 100, n);
    cycn(31);
    chk("t6b_cnt3", ifa.count, 3);
    reset = 1'b1;
    cyc();
    chk("t6b_pulse", ifa.period_pulse, 0);
    chk("t6b_run",   ifa.running, 0);
    chk("t6b_cnt",   ifa.count, 0);
    chk("t6b_pwm",   ifa.pwm_out, 0);
    reset = 1'b0;
    ifa.enable = 1'b0;
    ifb.enable = 1'b0;
    cycn(2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
